// File: rtl/wb_master_controller.sv
// WISHBONE bus master that drains the PACKET2MESSAGE queue one message at a time.
// Requests the bus, walks the head message beat by beat, and reports progress
// (next chunk / retry / done / error) back to the queue.
module wb_master_controller #(
  parameter int unsigned N_BITS_BURST_LENGHT = 7,
  parameter int unsigned BUS_ADDRESS_WIDTH   = 32,
  parameter int unsigned BUS_DATA_WIDTH      = 32,
  parameter int unsigned BUS_SEL_WIDTH       = 4,
  parameter int unsigned BUS_TGA_WIDTH       = 4,
  parameter int unsigned BUS_TGC_WIDTH       = 4,
  parameter int unsigned TIMEOUT_CYCLES      = 16,
  parameter int unsigned BACKOFF_CYCLES      = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  // Message queue side
  input  logic                           r_bus_arbitration_i,
  input  logic [BUS_ADDRESS_WIDTH-1:0]   address_i,
  input  logic [BUS_DATA_WIDTH-1:0]      data_i,
  input  logic [BUS_SEL_WIDTH-1:0]       sel_i,
  input  logic [BUS_TGA_WIDTH-1:0]       tga_i,
  input  logic [BUS_TGC_WIDTH-1:0]       tgc_i,
  input  logic                           transaction_type_i,
  input  logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_i,
  output logic                           next_data_o,
  output logic                           retry_o,
  output logic                           message_transmitted_o,
  // Arbiter side
  output logic                           bus_req_o,
  input  logic                           bus_gnt_i,
  // WISHBONE master side
  output logic                           cyc_o,
  output logic                           stb_o,
  output logic                           we_o,
  output logic [BUS_ADDRESS_WIDTH-1:0]   adr_o,
  output logic [BUS_DATA_WIDTH-1:0]      dat_o,
  output logic [BUS_SEL_WIDTH-1:0]       sel_o,
  output logic [BUS_TGA_WIDTH-1:0]       tga_o,
  output logic [BUS_TGC_WIDTH-1:0]       tgc_o,
  output logic [2:0]                     cti_o,
  input  logic                           ack_i,
  input  logic                           rty_i,
  input  logic                           err_i,
  output logic                           error_o
);

  localparam int unsigned TimeoutW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BackoffW = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);
  localparam logic [BackoffW-1:0] BackoffLast = BackoffW'(BACKOFF_CYCLES - 1);
  localparam logic [BUS_ADDRESS_WIDTH-1:0] ByteStep = BUS_ADDRESS_WIDTH'(BUS_DATA_WIDTH / 8);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StBackoff} state_e;

  state_e                         state_q, state_d;
  logic [N_BITS_BURST_LENGHT-1:0] beat_q, beat_d;
  logic [TimeoutW-1:0]            timeout_q, timeout_d;
  logic [BackoffW-1:0]            backoff_q, backoff_d;

  logic in_xfer, last_beat;
  logic term_err, term_rty, term_abort, term_ack;

  // Termination decode, priority err > rty > timeout/grant loss > ack.
  assign in_xfer    = (state_q == StXfer);
  assign last_beat  = (beat_q == (burst_lenght_i - N_BITS_BURST_LENGHT'(1)));
  assign term_err   = in_xfer & err_i;
  assign term_rty   = in_xfer & ~err_i & rty_i;
  assign term_abort = in_xfer & ~err_i & ~rty_i &
                      (~bus_gnt_i | (~ack_i & (timeout_q == TimeoutLast)));
  assign term_ack   = in_xfer & ~err_i & ~rty_i & ~term_abort & ack_i;

  // Next-state and counter update.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    timeout_d = timeout_q;
    backoff_d = backoff_q;
    unique case (state_q)
      StIdle: begin
        if (r_bus_arbitration_i) state_d = StReq;
      end
      StReq: begin
        if (bus_gnt_i) begin
          state_d   = StXfer;
          beat_d    = '0;
          timeout_d = '0;
        end
      end
      StXfer: begin
        if (term_err) begin
          state_d = StIdle;
        end else if (term_rty || term_abort) begin
          state_d   = StBackoff;
          backoff_d = '0;
        end else if (term_ack) begin
          timeout_d = '0;
          if (last_beat) state_d = StIdle;
          else           beat_d  = beat_q + N_BITS_BURST_LENGHT'(1);
        end else begin
          timeout_d = timeout_q + TimeoutW'(1);
        end
      end
      StBackoff: begin
        if (backoff_q == BackoffLast) state_d   = StIdle;
        else                          backoff_d = backoff_q + BackoffW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      beat_q    <= '0;
      timeout_q <= '0;
      backoff_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      timeout_q <= timeout_d;
      backoff_q <= backoff_d;
    end
  end

  // Bus and queue outputs; pulses are same-cycle so the queue can advance on the edge.
  always_comb begin
    bus_req_o             = (state_q == StReq) | in_xfer;
    cyc_o                 = 1'b0;
    stb_o                 = 1'b0;
    we_o                  = 1'b0;
    adr_o                 = '0;
    dat_o                 = '0;
    sel_o                 = '0;
    tga_o                 = '0;
    tgc_o                 = '0;
    cti_o                 = 3'b000;
    next_data_o           = term_ack & ~last_beat;
    message_transmitted_o = (term_ack & last_beat) | term_err;
    retry_o               = term_rty | term_abort;
    error_o               = term_err;
    if (in_xfer) begin
      cyc_o = 1'b1;
      stb_o = 1'b1;
      we_o  = transaction_type_i;
      adr_o = address_i + BUS_ADDRESS_WIDTH'(beat_q) * ByteStep;
      dat_o = data_i;
      sel_o = sel_i;
      tga_o = tga_i;
      tgc_o = tgc_i;
      cti_o = last_beat ? 3'b111 : 3'b010;
    end
  end

endmodule

// File: tb/tb_wb_master_controller.sv
// Self-checking bench for wb_master_controller: a small message queue model feeds the DUT,
// and each scenario task predicts the per-cycle bus activity from the message contents.
module tb_wb_master_controller;

  localparam logic [4:0] PNone  = 5'b10000; // {bus_req, next_data, retry, done, error}
  localparam logic [4:0] PNext  = 5'b11000;
  localparam logic [4:0] PRetry = 5'b10100;
  localparam logic [4:0] PDone  = 5'b10010;
  localparam logic [4:0] PErr   = 5'b10011;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_bus_arbitration_i;
  logic [31:0] address_i, data_i;
  logic [3:0]  sel_i, tga_i, tgc_i;
  logic        transaction_type_i;
  logic [6:0]  burst_lenght_i;
  logic        next_data_o, retry_o, message_transmitted_o;
  logic        bus_req_o, bus_gnt_i;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o, tga_o, tgc_o;
  logic [2:0]  cti_o;
  logic        ack_i, rty_i, err_i, error_o;

  int vectors = 0;
  int miscompares = 0;

  // Queue model: circular store of up to 8 messages, head popped on message_transmitted_o.
  logic [31:0] q_base [8];
  int          q_len  [8];
  logic        q_we   [8];
  logic [3:0]  q_tga  [8];
  logic [3:0]  q_tgc  [8];
  logic [31:0] q_dat  [8][128];
  logic [3:0]  q_sel  [8][128];
  int          head = 0;
  int          n_msgs = 0;
  int          chunk = 0;

  assign r_bus_arbitration_i = (head != n_msgs);
  assign address_i           = q_base[head[2:0]];
  assign data_i              = q_dat[head[2:0]][chunk[6:0]];
  assign sel_i               = q_sel[head[2:0]][chunk[6:0]];
  assign tga_i               = q_tga[head[2:0]];
  assign tgc_i               = q_tgc[head[2:0]];
  assign transaction_type_i  = q_we[head[2:0]];
  assign burst_lenght_i      = 7'(q_len[head[2:0]]);

  always @(posedge clk) begin
    if (rst) chunk <= 0;
    else if (message_transmitted_o) begin
      chunk <= 0;
      head  <= head + 1;
    end else if (retry_o) chunk <= 0;
    else if (next_data_o) chunk <= chunk + 1;
  end

  logic [81:0] obs_bus;
  logic [4:0]  obs_p;
  assign obs_bus = {cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, tga_o, tgc_o, cti_o};
  assign obs_p   = {bus_req_o, next_data_o, retry_o, message_transmitted_o, error_o};

  wb_master_controller dut (
    .clk                   (clk),
    .rst                   (rst),
    .r_bus_arbitration_i   (r_bus_arbitration_i),
    .address_i             (address_i),
    .data_i                (data_i),
    .sel_i                 (sel_i),
    .tga_i                 (tga_i),
    .tgc_i                 (tgc_i),
    .transaction_type_i    (transaction_type_i),
    .burst_lenght_i        (burst_lenght_i),
    .next_data_o           (next_data_o),
    .retry_o               (retry_o),
    .message_transmitted_o (message_transmitted_o),
    .bus_req_o             (bus_req_o),
    .bus_gnt_i             (bus_gnt_i),
    .cyc_o                 (cyc_o),
    .stb_o                 (stb_o),
    .we_o                  (we_o),
    .adr_o                 (adr_o),
    .dat_o                 (dat_o),
    .sel_o                 (sel_o),
    .tga_o                 (tga_o),
    .tgc_o                 (tgc_o),
    .cti_o                 (cti_o),
    .ack_i                 (ack_i),
    .rty_i                 (rty_i),
    .err_i                 (err_i),
    .error_o               (error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected bus word for beat b of the head message: base + 4*b, chunk b data, cti by position.
  function automatic logic [81:0] exp_xfer(input int b);
    logic [2:0]  h;
    logic [31:0] a;
    logic [2:0]  cti;
    h   = head[2:0];
    a   = q_base[h] + 32'(b) * 32'd4;
    cti = (b == q_len[h] - 1) ? 3'b111 : 3'b010;
    return {1'b1, 1'b1, q_we[h], a, q_dat[h][b[6:0]], q_sel[h][b[6:0]], q_tga[h], q_tgc[h], cti};
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic load_msg(input logic [31:0] base, input int len, input logic we);
    logic [2:0] s;
    s         = n_msgs[2:0];
    q_base[s] = base;
    q_len[s]  = len;
    q_we[s]   = we;
    q_tga[s]  = 4'($urandom);
    q_tgc[s]  = 4'($urandom);
    for (int i = 0; i < 128; i++) begin
      q_dat[s][i] = $urandom;
      q_sel[s][i] = 4'($urandom);
    end
    n_msgs++;
  endtask

  // One IDLE cycle, then REQ held for `waits` ungranted cycles plus the granted one.
  task automatic arbitrate(input int waits, input string tag);
    bus_gnt_i = 1'b0; ack_i = 1'b0; rty_i = 1'b0; err_i = 1'b0;
    #4;
    vectors++;
    if (obs_bus !== 82'd0 || obs_p !== 5'b00000) begin
      $display("FAIL %s_idle: bus=%h pulses=%b, expected all zero", tag, obs_bus, obs_p);
      miscompares++;
    end
    adv();
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) bus_gnt_i = 1'b1;
      #4;
      vectors++;
      if (obs_bus !== 82'd0 || obs_p !== PNone) begin
        $display("FAIL %s_req cycle %0d: bus=%h pulses=%b, expected bus 0 pulses %b",
                 tag, i, obs_bus, obs_p, PNone);
        miscompares++;
      end
      adv();
    end
  endtask

  // One XFER cycle at beat b with the given slave response and grant.
  task automatic beat(input int b, input logic a, input logic r, input logic e, input logic g,
                      input logic [4:0] exp_p, input string tag);
    ack_i = a; rty_i = r; err_i = e; bus_gnt_i = g;
    #4;
    vectors++;
    if (obs_bus !== exp_xfer(b)) begin
      $display("FAIL %s_bus beat %0d: got %h, expected %h", tag, b, obs_bus, exp_xfer(b));
      miscompares++;
    end
    vectors++;
    if (obs_p !== exp_p) begin
      $display("FAIL %s_pulse beat %0d: got %b, expected %b", tag, b, obs_p, exp_p);
      miscompares++;
    end
    adv();
    ack_i = 1'b0; rty_i = 1'b0; err_i = 1'b0; bus_gnt_i = 1'b1;
  endtask

  // n cycles where the master must be off the bus (BACKOFF or IDLE with nothing started).
  task automatic quiet(input int n, input string tag);
    bus_gnt_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      #4;
      vectors++;
      if (obs_bus !== 82'd0 || obs_p !== 5'b00000) begin
        $display("FAIL %s cycle %0d: bus=%h pulses=%b, expected all zero", tag, i, obs_bus, obs_p);
        miscompares++;
      end
      adv();
    end
  endtask

  // Ack every remaining beat of the head message from beat `from` onwards.
  task automatic finish_msg(input int from, input string tag);
    int len;
    len = q_len[head[2:0]];
    for (int b = from; b < len; b++)
      beat(b, 1'b1, 1'b0, 1'b0, 1'b1, (b == len - 1) ? PDone : PNext, tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    adv();
    adv();
    #4;
    vectors++;
    if (obs_bus !== 82'd0 || obs_p !== 5'b00000) begin
      $display("FAIL reset: bus=%h pulses=%b, expected all zero", obs_bus, obs_p);
      miscompares++;
    end
    adv();
    rst = 1'b0;
    quiet(2, "reset_idle");
  endtask

  task automatic test_single_read();
    load_msg(32'h100, 1, 1'b0);
    arbitrate(2, "rd");
    beat(0, 1'b1, 1'b0, 1'b0, 1'b1, PDone, "rd");
    quiet(1, "rd_after");
  endtask

  task automatic test_write_burst();
    load_msg(32'h200, 4, 1'b1);
    arbitrate(int'($urandom_range(3, 0)), "wr");
    finish_msg(0, "wr");
    quiet(1, "wr_after");
  endtask

  task automatic test_random_bursts();
    for (int m = 0; m < 8; m++) begin
      logic [31:0] base;
      int len;
      base = (m == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      len  = (m == 0) ? 4 : int'($urandom_range(8, 1));
      load_msg(base, len, 1'($urandom));
      arbitrate(int'($urandom_range(3, 0)), "rnd");
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(3, 0)) beat(b, 1'b0, 1'b0, 1'b0, 1'b1, PNone, "rnd_stall");
        beat(b, 1'b1, 1'b0, 1'b0, 1'b1, (b == len - 1) ? PDone : PNext, "rnd");
      end
      quiet(1, "rnd_after");
    end
  endtask

  task automatic test_retry();
    load_msg(32'h200, 4, 1'b1);
    arbitrate(0, "rty");
    beat(0, 1'b1, 1'b0, 1'b0, 1'b1, PNext, "rty");
    beat(1, 1'b1, 1'b0, 1'b0, 1'b1, PNext, "rty");
    beat(2, 1'b0, 1'b1, 1'b0, 1'b1, PRetry, "rty_hit");
    quiet(4, "rty_backoff");
    arbitrate(1, "rty_again");
    finish_msg(0, "rty_restart");
    quiet(1, "rty_after");
  endtask

  task automatic test_timeout_err();
    load_msg(32'h300, 2, 1'b0);
    arbitrate(0, "to");
    // Stalls before an ack must not carry into the next beat's timeout window.
    repeat (10) beat(0, 1'b0, 1'b0, 1'b0, 1'b1, PNone, "to_stall0");
    beat(0, 1'b1, 1'b0, 1'b0, 1'b1, PNext, "to_ack0");
    repeat (15) beat(1, 1'b0, 1'b0, 1'b0, 1'b1, PNone, "to_stall1");
    beat(1, 1'b0, 1'b0, 1'b0, 1'b1, PRetry, "to_expire");
    quiet(4, "to_backoff");
    arbitrate(0, "err");
    beat(0, 1'b0, 1'b0, 1'b1, 1'b1, PErr, "err");
    quiet(1, "err_after");
  endtask

  task automatic test_grant_loss();
    load_msg(32'h400, 4, 1'b1);
    arbitrate(0, "gnt");
    beat(0, 1'b1, 1'b0, 1'b0, 1'b1, PNext, "gnt");
    beat(1, 1'b1, 1'b0, 1'b0, 1'b0, PRetry, "gnt_lost");
    quiet(4, "gnt_backoff");
    arbitrate(0, "gnt_again");
    finish_msg(0, "gnt_restart");
    quiet(1, "gnt_after");
  endtask

  task automatic test_reset_mid();
    load_msg(32'h500, 3, 1'b1);
    arbitrate(0, "rstm");
    beat(0, 1'b1, 1'b0, 1'b0, 1'b1, PNext, "rstm");
    rst = 1'b1;
    adv();
    rst = 1'b0;
    // First cycle after reset must be an all-zero IDLE cycle, then normal arbitration.
    arbitrate(0, "rstm_post");
    finish_msg(0, "rstm_restart");
    quiet(1, "rstm_after");
  endtask

  task automatic test_back_to_back();
    load_msg(32'h600, 2, 1'b1);
    load_msg(32'h700, 3, 1'b0);
    arbitrate(1, "b2b_first");
    finish_msg(0, "b2b_first");
    arbitrate(0, "b2b_second");
    beat(0, 1'b1, 1'b1, 1'b0, 1'b1, PRetry, "b2b_ack_rty");
    quiet(4, "b2b_backoff");
    arbitrate(0, "b2b_again");
    finish_msg(0, "b2b_second");
    quiet(1, "b2b_after");
  endtask

  initial begin
    rst = 1'b1; bus_gnt_i = 1'b0; ack_i = 1'b0; rty_i = 1'b0; err_i = 1'b0;
    test_reset();
    test_single_read();
    test_write_burst();
    test_random_bursts();
    test_retry();
    test_timeout_err();
    test_grant_loss();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_master_controller.md
Name: wb_master_controller

Overview:
- Sequences the PACKET2MESSAGE message queue onto the WISHBONE bus as a bus master.
- Requests the bus from the system arbiter and drives WISHBONE master signals, using the address, data, sel and tag outputs of the queue's head message.
- Pulses next_data / retry / message_transmitted back to the queue.
- Handles ACK, RTY and ERR terminations, an ACK timeout and a post-retry backoff.

Parameters:
N_BITS_BURST_LENGHT, 7, width of burst length and beat counter
BUS_ADDRESS_WIDTH, 32, WISHBONE address width
BUS_DATA_WIDTH, 32, WISHBONE data width (byte address step = BUS_DATA_WIDTH/8)
BUS_SEL_WIDTH, 4, WISHBONE SEL width
BUS_TGA_WIDTH, 4, address tag width (source)
BUS_TGC_WIDTH, 4, cycle tag width (command)
TIMEOUT_CYCLES, 16, cycles without termination in XFER before forced retry
BACKOFF_CYCLES, 4, idle cycles after a retry before re-requesting

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
r_bus_arbitration_i  input  1  queue holds a message at head
address_i  input  BUS_ADDRESS_WIDTH  base address of head message
data_i  input  BUS_DATA_WIDTH  current chunk from queue
sel_i  input  BUS_SEL_WIDTH  current chunk byte select
tga_i  input  BUS_TGA_WIDTH  source tag
tgc_i  input  BUS_TGC_WIDTH  command tag
transaction_type_i  input  1  1=write, 0=read
burst_lenght_i  input  N_BITS_BURST_LENGHT  beats in message (>=1)
next_data_o  output  1  advance queue chunk pointer
retry_o  output  1  restart current message
message_transmitted_o  output  1  head message done, pop
bus_req_o  output  1  request to bus arbiter
bus_gnt_i  input  1  grant from bus arbiter
cyc_o  output  1  WB CYC_O
stb_o  output  1  WB STB_O
we_o  output  1  WB WE_O
adr_o  output  BUS_ADDRESS_WIDTH  WB ADR_O
dat_o  output  BUS_DATA_WIDTH  WB DAT_O
sel_o  output  BUS_SEL_WIDTH  WB SEL_O
tga_o  output  BUS_TGA_WIDTH  WB TGA_O
tgc_o  output  BUS_TGC_WIDTH  WB TGC_O
cti_o  output  3  WB CTI_O
ack_i  input  1  WB ACK_I
rty_i  input  1  WB RTY_I
err_i  input  1  WB ERR_I
error_o  output  1  one-cycle pulse: message dropped on ERR

Behaviour:
- Clock/reset: one clock clk; rst synchronous active-high. Reset (also mid-transfer): state IDLE, beat/timeout/backoff counters 0, all outputs 0 in the cycle after rst is sampled.
- FSM states: IDLE, REQ, XFER, BACKOFF.
- IDLE: r_bus_arbitration_i=1 -> REQ next cycle.
- REQ: bus_req_o=1. bus_gnt_i=1 -> XFER next cycle, beat=0, timeout=0.
- XFER outputs and counters:
  - bus_req_o=cyc_o=stb_o=1.
  - we_o=transaction_type_i.
  - adr_o=address_i+beat*(BUS_DATA_WIDTH/8), modulo 2^BUS_ADDRESS_WIDTH.
  - dat_o/sel_o/tga_o/tgc_o pass through from inputs.
  - cti_o=3'b111 when beat==burst_lenght_i-1 (includes burst 1), else 3'b010.
  - Timeout counter increments each XFER cycle without ack/rty/err and clears on ack.
- XFER terminations, priority err > rty > timeout/grant loss > ack:
  - ack_i, beat<burst_lenght_i-1: next_data_o=1 same cycle (combinational); beat+1; stay XFER.
  - ack_i, last beat: message_transmitted_o=1 same cycle; -> IDLE; cyc_o/stb_o low next cycle.
  - rty_i: retry_o=1 same cycle; -> BACKOFF; backoff counter=0.
  - err_i: message_transmitted_o=1 and error_o=1 same cycle (message dropped); -> IDLE.
  - timeout counter reaching TIMEOUT_CYCLES-1 with no termination, or bus_gnt_i=0 while in XFER: retry_o=1; -> BACKOFF.
- BACKOFF: all bus outputs 0; counts BACKOFF_CYCLES cycles, then -> IDLE.
- Pulse rule: next_data_o, retry_o, message_transmitted_o, error_o are mutually exclusive single-cycle pulses, only asserted in XFER.
- Outside XFER: cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, tga_o, tgc_o, cti_o are 0.
- Inter-message gap: at least one IDLE cycle between messages; back-to-back messages re-arbitrate via REQ.
- Burst input: burst_lenght_i sampled combinationally; the queue holds it stable while the head is unchanged.

Test Plan:
- Single read (burst 1, we=0, addr 0x100): grant after 2 cycles, ack in first XFER cycle -> cti=111, message_transmitted_o 1 cycle, no next_data_o, cyc_o low next cycle.
- Write burst 4 (addr 0x200), ack every cycle -> adr 0x200/0x204/0x208/0x20C, cti 010,010,010,111, next_data_o x3, message_transmitted_o x1.
- Burst 4, rty_i on beat 2 -> retry_o pulse, cyc_o drops, 4 BACKOFF cycles, REQ again, restart at adr 0x200 beat 0.
- No ack for 16 XFER cycles -> retry_o on 16th cycle, BACKOFF; err_i on beat 0 -> message_transmitted_o+error_o, IDLE.
- Grant withdrawn mid-burst -> retry_o; rst asserted mid-burst -> all outputs 0 next cycle, FSM IDLE.
- Two queued messages: second starts with REQ after an IDLE cycle; simultaneous ack+rty -> retry wins.
